dmem_resp: RTL and testbench

Multi-cycle data-memory responder serving the MEM stage of the 5-stage MIPS pipeline. It accepts one load or store request at a time from the MEM stage (address, store data, MemRead, MemWrite), stalls the pipeline for a programmable latency, then completes the access and returns load data with a one-cycle valid pulse. It replaces the single-cycle data memory wherever realistic memory latency and pipeline back-pressure must be modelled.

---
 rtl/dmem_resp.sv | 141 ++++++++++++++
 tb/tb_dmem_resp.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// ============================================================================
// Module   : dmem_resp
// Purpose  : Multi-cycle data-memory responder for the MIPS MEM stage, with
//            programmable latency, pipeline stall and a load-valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_resp #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUres,
    input  logic [31:0] wdata,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic        stall,
    output logic [31:0] Rdata,
    output logic        rvalid,
    output logic        err
);

    localparam int         c_AW       = $clog2(DEPTH);
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;
    logic [c_AW-1:0] r_idx;
    logic [31:0]     r_wdata;
    logic            r_wr;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic [31:0]     r_mem [DEPTH];

    logic            w_stall;
    logic            w_rvalid;
    logic            w_req;
    logic            w_bad;
    logic            w_accept;
    logic            w_reject;
    logic [c_AW-1:0] w_idx_in;
    logic [c_AW-1:0] w_ld_idx;
    logic            w_ld;

    assign w_idx_in = ALUres[c_AW+1:2];
    assign w_req    = MemRead | MemWrite;
    assign w_bad    = (MemRead & MemWrite) | (|ALUres[1:0]);
    assign w_accept = (r_state == S_IDLE) && w_req && !w_bad;
    assign w_reject = (r_state == S_IDLE) && w_req && w_bad;

    // Rdata loads on the edge entering DONE; with LATENCY==1 that edge is
    // the acceptance edge itself, so the live inputs must be used.
    assign w_ld_idx = (r_state == S_IDLE) ? w_idx_in : r_idx;
    assign w_ld     = (r_state == S_IDLE) ? MemRead  : !r_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_stall  = 1'b0;
        w_rvalid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_stall = 1'b1;
                    w_next  = (LATENCY == 1) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (r_cnt == 4'd1) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_rvalid = !r_wr;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_wr    <= 1'b0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_accept) begin
                r_cnt   <= c_CNT_INIT;
                r_idx   <= w_idx_in;
                r_wdata <= wdata;
                r_wr    <= MemWrite;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if ((w_next == S_DONE) && (r_state != S_DONE) && w_ld) begin
                r_rdata <= r_mem[w_ld_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if ((r_state == S_DONE) && r_wr) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign stall  = w_stall;
    assign rvalid = w_rvalid;
    assign err    = r_err;
    assign Rdata  = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_resp.sv
// ============================================================================
// Module   : tb_dmem_resp
// Purpose  : Directed self-checking bench for dmem_resp (LATENCY 2 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_resp;

    logic        clk;
    logic        rst;

    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_rd, a_wr, a_stall, a_rvalid, a_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        b_rd, b_wr, b_stall, b_rvalid, b_err;

    int checks   = 0;
    int failures = 0;

    dmem_resp #(.DEPTH(256), .LATENCY(2)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .ALUres   (a_addr),
        .wdata    (a_wdata),
        .MemRead  (a_rd),
        .MemWrite (a_wr),
        .stall    (a_stall),
        .Rdata    (a_rdata),
        .rvalid   (a_rvalid),
        .err      (a_err)
    );

    dmem_resp #(.DEPTH(256), .LATENCY(1)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .ALUres   (b_addr),
        .wdata    (b_wdata),
        .MemRead  (b_rd),
        .MemWrite (b_wr),
        .stall    (b_stall),
        .Rdata    (b_rdata),
        .rvalid   (b_rvalid),
        .err      (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // LATENCY=2 access: called just after a rising edge, returns likewise.
    task automatic acc_a(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_rdata);
        a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = data;
        @(negedge clk);
        check("a_stall_t0", {31'd0, a_stall}, 32'd1);
        check("a_rvalid_t0", {31'd0, a_rvalid}, 32'd0);
        @(posedge clk); #1;
        a_rd = 1'b0; a_wr = 1'b0; a_addr = 32'hFFFF_FFFF; a_wdata = 32'h5A5A_5A5A;
        @(negedge clk);
        check("a_stall_t1", {31'd0, a_stall}, 32'd1);
        check("a_rvalid_t1", {31'd0, a_rvalid}, 32'd0);
        @(posedge clk); #1;
        a_addr = 32'd0;
        @(negedge clk);
        check("a_stall_done", {31'd0, a_stall}, 32'd0);
        check("a_rvalid_done", {31'd0, a_rvalid}, {31'd0, rd});
        check("a_rdata_done", a_rdata, exp_rdata);
        @(posedge clk); #1;
    endtask

    task automatic reject_a(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] exp_rdata);
        a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("rej_stall_t0", {31'd0, a_stall}, 32'd0);
        check("rej_err_t0", {31'd0, a_err}, 32'd0);
        @(posedge clk); #1;
        a_rd = 1'b0; a_wr = 1'b0; a_addr = 32'd0;
        @(negedge clk);
        check("rej_err_t1", {31'd0, a_err}, 32'd1);
        check("rej_stall_t1", {31'd0, a_stall}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rej_err_t2", {31'd0, a_err}, 32'd0);
        check("rej_rvalid", {31'd0, a_rvalid}, 32'd0);
        check("rej_rdata", a_rdata, exp_rdata);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] last_b;
        rst = 1'b1;
        a_rd = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
        b_rd = 0; b_wr = 0; b_addr = 0; b_wdata = 0;
        @(negedge clk);
        check("rst_a_stall", {31'd0, a_stall}, 32'd0);
        check("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        check("rst_a_err", {31'd0, a_err}, 32'd0);
        check("rst_a_rdata", a_rdata, 32'd0);
        check("rst_b_stall", {31'd0, b_stall}, 32'd0);
        check("rst_b_rdata", b_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic load, store then back-to-back load
        acc_a(1'b1, 1'b0, 32'h40, 32'd0, 32'h0000_0000);
        acc_a(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0000_0000);
        acc_a(1'b1, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF);
        acc_a(1'b1, 1'b0, 32'h14, 32'd0, 32'h0000_0000);

        // Rejected requests leave Rdata and memory alone
        reject_a(1'b1, 1'b0, 32'h13, 32'h0000_0000);
        reject_a(1'b1, 1'b1, 32'h20, 32'h0000_0000);
        acc_a(1'b1, 1'b0, 32'h20, 32'd0, 32'h0000_0000);
        acc_a(1'b1, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF);

        // Address wrap: word 256 aliases word 0
        acc_a(1'b0, 1'b1, 32'h400, 32'h1234_5678, 32'hDEAD_BEEF);
        acc_a(1'b1, 1'b0, 32'h000, 32'd0, 32'h1234_5678);

        // Reset during WAIT of a store
        a_rd = 1'b0; a_wr = 1'b1; a_addr = 32'h30; a_wdata = 32'hAAAA_5555;
        @(negedge clk);
        check("rw_stall_t0", {31'd0, a_stall}, 32'd1);
        @(posedge clk); #1;
        a_wr = 1'b0; a_addr = 32'd0;
        #2 rst = 1'b1;
        #1;
        check("rw_stall_async", {31'd0, a_stall}, 32'd0);
        check("rw_rvalid_async", {31'd0, a_rvalid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rw_rvalid_after", {31'd0, a_rvalid}, 32'd0);
        check("rw_rdata_cleared", a_rdata, 32'd0);
        @(posedge clk); #1;
        acc_a(1'b1, 1'b0, 32'h30, 32'd0, 32'h0000_0000);
        acc_a(1'b1, 1'b0, 32'h00, 32'd0, 32'h0000_0000);

        // LATENCY=1 alternating store/load stream with toggled inputs in DONE
        last_b = 32'd0;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 2; k++) begin
                b_rd = (k == 1); b_wr = (k == 0);
                b_addr = 32'(i * 4); b_wdata = 32'hC0DE_0000 | 32'(i);
                @(negedge clk);
                check("b_stall_t0", {31'd0, b_stall}, 32'd1);
                check("b_rvalid_t0", {31'd0, b_rvalid}, 32'd0);
                @(posedge clk); #1;
                b_rd = ~b_rd; b_wr = ~b_wr; b_addr = 32'h7C; b_wdata = 32'hBAD0_BAD0;
                @(negedge clk);
                check("b_stall_done", {31'd0, b_stall}, 32'd0);
                check("b_rvalid_done", {31'd0, b_rvalid}, (k == 1) ? 32'd1 : 32'd0);
                if (k == 1) last_b = 32'hC0DE_0000 | 32'(i);
                check("b_rdata", b_rdata, last_b);
                @(posedge clk); #1;
            end
        end
        b_rd = 1'b1; b_wr = 1'b0; b_addr = 32'h7C;
        @(posedge clk); #1;
        b_rd = 1'b0;
        @(negedge clk);
        check("b_toggled_store_ignored", b_rdata, 32'd0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
